// File: rtl/hc8_dma_ctrl.sv
// hc8_dma_ctrl: two-channel block copy / fill DMA for the HC8 bus.
// Takes the bus from the CPU via nDMA_REQ and hands it back when done.
//
// Ports:
//   clk, nReset        system clock, async active-low reset
//   chN_req            level request, held until chN_done
//   chN_fill           1 = fill dst with chN_src[7:0], 0 = copy src->dst
//   chN_src/dst/len    source (or fill byte), destination, byte count
//   chN_done           one-cycle completion pulse
//   nDMA_REQ           bus request to the CPU, active low
//   address_bus        driven in READ/WRITE only, else Z
//   data_bus           driven in WRITE only, else Z
//   nRAM_RD/nRAM_WR    strobes, low only in clk-low half; Z when not owner
//   busy               high in any state other than IDLE
//   active_ch          channel being serviced; holds its value in IDLE
module hc8_dma_ctrl #(
   parameter int TURNAROUND = 1
) (
   input  logic        clk,
   input  logic        nReset,
   input  logic        ch0_req,
   input  logic        ch0_fill,
   input  logic [15:0] ch0_src,
   input  logic [15:0] ch0_dst,
   input  logic [7:0]  ch0_len,
   output logic        ch0_done,
   input  logic        ch1_req,
   input  logic        ch1_fill,
   input  logic [15:0] ch1_src,
   input  logic [15:0] ch1_dst,
   input  logic [7:0]  ch1_len,
   output logic        ch1_done,
   output logic        nDMA_REQ,
   output logic [15:0] address_bus,
   inout  wire  [7:0]  data_bus,
   output logic        nRAM_RD,
   output logic        nRAM_WR,
   output logic        busy,
   output logic        active_ch
);

   typedef enum logic [2:0] {
      IDLE,
      ZERO,
      REQ,
      READ,
      WRITE,
      REL,
      DONE
   } state_t;

   localparam logic [2:0] TCNT_INIT = 3'(TURNAROUND - 1);

   state_t      state;
   logic [2:0]  tcnt;
   logic        fill_q;
   logic [15:0] src_q;
   logic [15:0] dst_q;
   logic [7:0]  len_q;
   logic [7:0]  dat_q;
   logic        rr_last;
   logic        drv_q;
   logic        rd_q;
   logic        wr_q;

   logic        grant;
   logic        g_fill;
   logic [15:0] g_src;
   logic [15:0] g_dst;
   logic [7:0]  g_len;

   // Tie goes to the channel that was not served last.
   always_comb begin
      grant = 1'b0;
      unique case (1'b1)
         (ch0_req & ch1_req):  grant = ~rr_last;
         (ch1_req & ~ch0_req): grant = 1'b1;
         default:              grant = 1'b0;
      endcase
   end

   assign g_fill = grant ? ch1_fill : ch0_fill;
   assign g_src  = grant ? ch1_src  : ch0_src;
   assign g_dst  = grant ? ch1_dst  : ch0_dst;
   assign g_len  = grant ? ch1_len  : ch0_len;

   // Strobes follow clk so they can only be low in the clk-low half.
   assign address_bus = drv_q ? (wr_q ? dst_q : src_q) : 16'hzzzz;
   assign nRAM_RD     = drv_q ? ~(rd_q & ~clk) : 1'bz;
   assign nRAM_WR     = drv_q ? ~(wr_q & ~clk) : 1'bz;
   assign data_bus    = wr_q ? (fill_q ? src_q[7:0] : dat_q) : 8'hzz;

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state     <= IDLE;
         tcnt      <= 3'd0;
         fill_q    <= 1'b0;
         src_q     <= 16'h0000;
         dst_q     <= 16'h0000;
         len_q     <= 8'h00;
         dat_q     <= 8'h00;
         rr_last   <= 1'b1;
         active_ch <= 1'b0;
         nDMA_REQ  <= 1'b1;
         busy      <= 1'b0;
         ch0_done  <= 1'b0;
         ch1_done  <= 1'b0;
         drv_q     <= 1'b0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
      end else begin
         ch0_done <= 1'b0;
         ch1_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (ch0_req | ch1_req) begin
                  active_ch <= grant;
                  rr_last   <= grant;
                  fill_q    <= g_fill;
                  src_q     <= g_src;
                  dst_q     <= g_dst;
                  len_q     <= g_len;
                  busy      <= 1'b1;
                  if (g_len == 8'h00) begin
                     state <= ZERO;
                  end else begin
                     state    <= REQ;
                     nDMA_REQ <= 1'b0;
                     tcnt     <= TCNT_INIT;
                  end
               end
            end
            ZERO: begin
               state    <= DONE;
               ch0_done <= ~active_ch;
               ch1_done <= active_ch;
            end
            REQ: begin
               // Bus stays Z while the CPU lets go of it.
               if (tcnt == 3'd0) begin
                  drv_q <= 1'b1;
                  if (fill_q) begin
                     state <= WRITE;
                     wr_q  <= 1'b1;
                  end else begin
                     state <= READ;
                     rd_q  <= 1'b1;
                  end
               end else begin
                  tcnt <= tcnt - 3'd1;
               end
            end
            READ: begin
               dat_q <= data_bus;
               rd_q  <= 1'b0;
               wr_q  <= 1'b1;
               state <= WRITE;
            end
            WRITE: begin
               dst_q <= dst_q + 16'd1;
               len_q <= len_q - 8'd1;
               if (!fill_q) src_q <= src_q + 16'd1;
               if (len_q == 8'd1) begin
                  state    <= REL;
                  wr_q     <= 1'b0;
                  drv_q    <= 1'b0;
                  nDMA_REQ <= 1'b1;
               end else if (!fill_q) begin
                  state <= READ;
                  wr_q  <= 1'b0;
                  rd_q  <= 1'b1;
               end
            end
            REL: begin
               state    <= DONE;
               ch0_done <= ~active_ch;
               ch1_done <= active_ch;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hc8_dma_ctrl.sv
// tb_hc8_dma_ctrl: bench for hc8_dma_ctrl with RAM, CPU and byte model.
// Ports: none (top-level bench).
module tb_hc8_dma_ctrl;

   localparam int TURN = 1;

   logic        clk = 1'b0;
   logic        nReset = 1'b0;
   logic        ch0_req = 1'b0, ch0_fill = 1'b0;
   logic [15:0] ch0_src = '0, ch0_dst = '0;
   logic [7:0]  ch0_len = '0;
   logic        ch0_done;
   logic        ch1_req = 1'b0, ch1_fill = 1'b0;
   logic [15:0] ch1_src = '0, ch1_dst = '0;
   logic [7:0]  ch1_len = '0;
   logic        ch1_done;
   logic        nDMA_REQ, busy, active_ch;
   tri1  [15:0] address_bus;
   tri1  [7:0]  data_bus;
   tri1         nRAM_RD;
   tri1         nRAM_WR;

   logic        rd_drv = 1'b0;
   logic [7:0]  rd_val = 8'h00;
   assign data_bus = rd_drv ? rd_val : 8'hzz;

   logic [7:0]  mem     [0:65535];
   logic [7:0]  ref_mem [0:65535];
   logic [15:0] rd_log[$];
   logic [15:0] wr_log[$];
   int          rd_cnt = 0, wr_cnt = 0, hyg_err = 0, low_run = 0;
   int unsigned pc = 0;
   int          tests = 0, fails = 0;
   bit          rr = 1'b1;

   hc8_dma_ctrl #(.TURNAROUND(TURN)) dut (
      .clk(clk), .nReset(nReset),
      .ch0_req(ch0_req), .ch0_fill(ch0_fill), .ch0_src(ch0_src),
      .ch0_dst(ch0_dst), .ch0_len(ch0_len), .ch0_done(ch0_done),
      .ch1_req(ch1_req), .ch1_fill(ch1_fill), .ch1_src(ch1_src),
      .ch1_dst(ch1_dst), .ch1_len(ch1_len), .ch1_done(ch1_done),
      .nDMA_REQ(nDMA_REQ), .address_bus(address_bus),
      .data_bus(data_bus), .nRAM_RD(nRAM_RD), .nRAM_WR(nRAM_WR),
      .busy(busy), .active_ch(active_ch)
   );

   always #5 clk = ~clk;

   // CPU fetches one byte per cycle whenever it owns the bus.
   always @(posedge clk or negedge nReset)
      if (!nReset) pc <= 0;
      else if (nDMA_REQ) pc <= pc + 1;

   // RAM plus bus hygiene monitor.
   always begin
      @(negedge clk); #1;
      if (nRAM_RD === 1'b0 && nRAM_WR === 1'b0) hyg_err++;
      if (nDMA_REQ !== 1'b0 && (nRAM_RD !== 1'b1 || nRAM_WR !== 1'b1 ||
          address_bus !== 16'hFFFF)) hyg_err++;
      if (nRAM_RD === 1'b0) begin
         rd_cnt++;
         rd_log.push_back(address_bus);
         rd_val <= mem[address_bus];
         rd_drv <= 1'b1;
      end
      if (nRAM_WR === 1'b0) begin
         wr_cnt++;
         wr_log.push_back(address_bus);
         mem[address_bus] = data_bus;
      end
      @(posedge clk);
      rd_drv <= 1'b0;
      #1;
      if (nDMA_REQ === 1'b0) low_run++;
      else low_run = 0;
      if (nRAM_RD === 1'b0 || nRAM_WR === 1'b0) hyg_err++;
      if ((nDMA_REQ !== 1'b0 || low_run <= TURN) &&
          (address_bus !== 16'hFFFF || data_bus !== 8'hFF)) hyg_err++;
   end

   function automatic int exp_cycles(bit fill, int len);
      return (len == 0) ? 2 : TURN + (fill ? len : 2 * len) + 2;
   endfunction

   function automatic int exp_low(bit fill, int len);
      return (len == 0) ? 0 : TURN + (fill ? len : 2 * len);
   endfunction

   task automatic model_xfer(input bit fill, input logic [15:0] src,
                             input logic [15:0] dst, input int len);
      for (int i = 0; i < len; i++) begin
         logic [15:0] s, d;
         s = src + 16'(i);
         d = dst + 16'(i);
         ref_mem[d] = fill ? src[7:0] : ref_mem[s];
      end
   endtask

   function automatic int region_diff(logic [15:0] dst, int len);
      int b = 0;
      for (int i = 0; i <= len; i++) begin
         logic [15:0] a;
         a = dst + 16'(i);
         if (mem[a] !== ref_mem[a]) b++;
      end
      return b;
   endfunction

   task automatic start_ch(input bit ch, input bit fill, input logic [15:0] src,
                           input logic [15:0] dst, input logic [7:0] len);
      if (ch) begin
         ch1_fill = fill; ch1_src = src; ch1_dst = dst; ch1_len = len;
         ch1_req = 1'b1;
      end else begin
         ch0_fill = fill; ch0_src = src; ch0_dst = dst; ch0_len = len;
         ch0_req = 1'b1;
      end
   endtask

   task automatic watch(output int cyc, output int low, output int d0,
                        output int d1, output int unsigned pcr,
                        output int unsigned pcl, output logic act,
                        output bit to);
      bit started, seen_low, seen_rel, fin;
      cyc = 0; low = 0; d0 = 0; d1 = 0; pcr = 0; pcl = 0; act = 1'b0;
      to = 1'b1; started = 0; seen_low = 0; seen_rel = 0; fin = 0;
      for (int n = 0; n < 1000 && !fin; n++) begin
         @(posedge clk); #1;
         if (busy === 1'b1) started = 1;
         if (started) cyc++;
         if (nDMA_REQ === 1'b0) begin
            low++;
            if (!seen_low) begin seen_low = 1; pcr = pc; end
         end else if (seen_low && !seen_rel) begin
            seen_rel = 1; pcl = pc;
         end
         if (ch0_done === 1'b1) d0++;
         if (ch1_done === 1'b1) d1++;
         if (ch0_done === 1'b1 || ch1_done === 1'b1) begin
            fin = 1; to = 1'b0; act = active_ch;
            if (ch0_done === 1'b1) ch0_req = 1'b0;
            if (ch1_done === 1'b1) ch1_req = 1'b0;
         end
      end
      @(posedge clk); #1;
      if (ch0_done === 1'b1) d0++;
      if (ch1_done === 1'b1) d1++;
   endtask

   task automatic apply_reset();
      ch0_req = 1'b0; ch1_req = 1'b0;
      nReset = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      nReset = 1'b1;
      rr = 1'b1;
   endtask

   task automatic test_reset();
      nReset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++; if (nDMA_REQ !== 1'b1) begin fails++; $display("FAIL rst_ndma got %b want 1", nDMA_REQ); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
      tests++; if (active_ch !== 1'b0) begin fails++; $display("FAIL rst_active got %b want 0", active_ch); end
      tests++; if ({ch0_done, ch1_done} !== 2'b00) begin fails++; $display("FAIL rst_done got %b want 00", {ch0_done, ch1_done}); end
      tests++; if (address_bus !== 16'hFFFF || data_bus !== 8'hFF) begin fails++; $display("FAIL rst_bus got %h/%h want released", address_bus, data_bus); end
      tests++; if ({nRAM_RD, nRAM_WR} !== 2'b11) begin fails++; $display("FAIL rst_strobes got %b want released", {nRAM_RD, nRAM_WR}); end
      @(negedge clk);
      nReset = 1'b1;
      rr = 1'b1;
   endtask

   task automatic test_copy();
      int cyc, low, d0, d1; int unsigned pcr, pcl; logic act; bit to;
      mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22; mem[16'h0102] = 8'h33;
      ref_mem[16'h0100] = 8'h11; ref_mem[16'h0101] = 8'h22; ref_mem[16'h0102] = 8'h33;
      start_ch(1'b0, 1'b0, 16'h0100, 16'h0200, 8'd3);
      model_xfer(1'b0, 16'h0100, 16'h0200, 3);
      rr = 1'b0;
      watch(cyc, low, d0, d1, pcr, pcl, act, to);
      tests++; if (to) begin fails++; $display("FAIL copy_timeout got no done want done"); end
      tests++; if (cyc != exp_cycles(0, 3)) begin fails++; $display("FAIL copy_cycles got %0d want %0d", cyc, exp_cycles(0, 3)); end
      tests++; if (low != exp_low(0, 3)) begin fails++; $display("FAIL copy_ndma_low got %0d want %0d", low, exp_low(0, 3)); end
      tests++; if (d0 != 1 || d1 != 0) begin fails++; $display("FAIL copy_done got %0d/%0d want 1/0", d0, d1); end
      tests++; if (pcr != pcl) begin fails++; $display("FAIL copy_pc_frozen got %0d want %0d", pcl, pcr); end
      tests++; if (mem[16'h0202] !== 8'h33 || region_diff(16'h0200, 3) != 0) begin fails++; $display("FAIL copy_data got %h want 33", mem[16'h0202]); end
   endtask

   task automatic test_fill();
      int cyc, low, d0, d1; int unsigned pcr, pcl; logic act; bit to;
      rd_cnt = 0; wr_cnt = 0;
      start_ch(1'b1, 1'b1, 16'h00A5, 16'h0300, 8'd4);
      model_xfer(1'b1, 16'h00A5, 16'h0300, 4);
      rr = 1'b1;
      watch(cyc, low, d0, d1, pcr, pcl, act, to);
      tests++; if (to) begin fails++; $display("FAIL fill_timeout got no done want done"); end
      tests++; if (cyc != exp_cycles(1, 4)) begin fails++; $display("FAIL fill_cycles got %0d want %0d", cyc, exp_cycles(1, 4)); end
      tests++; if (rd_cnt != 0 || wr_cnt != 4) begin fails++; $display("FAIL fill_strobes got rd %0d wr %0d want 0/4", rd_cnt, wr_cnt); end
      tests++; if (d1 != 1 || d0 != 0 || act !== 1'b1) begin fails++; $display("FAIL fill_done got %0d/%0d ch %b want 0/1 ch 1", d0, d1, act); end
      tests++; if (region_diff(16'h0300, 4) != 0) begin fails++; $display("FAIL fill_data got %0d bad bytes want 0", region_diff(16'h0300, 4)); end
   endtask

   task automatic test_arbitration();
      bit          pf [2];
      logic [15:0] ps [2];
      logic [15:0] pd [2];
      logic [7:0]  pl [2];
      int cyc, low, d0, d1; int unsigned pcr, pcl; logic act; bit to;
      bit w;
      apply_reset();
      pf[0] = 1'b0; ps[0] = 16'h0600; pd[0] = 16'h0610; pl[0] = 8'd2;
      pf[1] = 1'b1; ps[1] = 16'h005A; pd[1] = 16'h0620; pl[1] = 8'd3;
      for (int rep = 0; rep < 2; rep++) begin
         start_ch(1'b0, pf[0], ps[0], pd[0], pl[0]);
         start_ch(1'b1, pf[1], ps[1], pd[1], pl[1]);
         for (int s = 0; s < 2; s++) begin
            w = (ch0_req && ch1_req) ? ~rr : ch1_req;
            rr = w;
            model_xfer(pf[w], ps[w], pd[w], int'(pl[w]));
            watch(cyc, low, d0, d1, pcr, pcl, act, to);
            tests++;
            if (to || act !== w || (w ? d1 : d0) != 1 || (w ? d0 : d1) != 0) begin
               fails++;
               $display("FAIL arb_order rep %0d slot %0d got ch %b done %0d/%0d want ch %b", rep, s, act, d0, d1, w);
            end
            tests++; if (region_diff(pd[w], int'(pl[w])) != 0) begin fails++; $display("FAIL arb_data got %0d bad bytes want 0", region_diff(pd[w], int'(pl[w]))); end
         end
      end
   endtask

   task automatic test_zero_len();
      int cyc, low, d0, d1; int unsigned pcr, pcl; logic act; bit to;
      wr_cnt = 0;
      start_ch(1'b0, 1'b0, 16'h1234, 16'h0700, 8'd0);
      rr = 1'b0;
      watch(cyc, low, d0, d1, pcr, pcl, act, to);
      tests++; if (to || cyc != 2) begin fails++; $display("FAIL zero_cycles got %0d want 2", cyc); end
      tests++; if (low != 0 || wr_cnt != 0) begin fails++; $display("FAIL zero_bus got low %0d wr %0d want 0/0", low, wr_cnt); end
      tests++; if (d0 != 1 || d1 != 0) begin fails++; $display("FAIL zero_done got %0d/%0d want 1/0", d0, d1); end
   endtask

   task automatic test_wrap();
      int cyc, low, d0, d1; int unsigned pcr, pcl; logic act; bit to;
      rd_log.delete(); wr_log.delete();
      start_ch(1'b0, 1'b0, 16'hFFFF, 16'h7FFF, 8'd2);
      model_xfer(1'b0, 16'hFFFF, 16'h7FFF, 2);
      rr = 1'b0;
      watch(cyc, low, d0, d1, pcr, pcl, act, to);
      tests++; if (to || rd_log.size() != 2 || rd_log[0] !== 16'hFFFF || rd_log[1] !== 16'h0000) begin
         fails++; $display("FAIL wrap_reads got %0d reads %h %h want FFFF 0000", rd_log.size(), rd_log[0], rd_log[1]); end
      tests++; if (wr_log.size() != 2 || wr_log[0] !== 16'h7FFF || wr_log[1] !== 16'h8000) begin
         fails++; $display("FAIL wrap_writes got %0d writes %h %h want 7FFF 8000", wr_log.size(), wr_log[0], wr_log[1]); end
      tests++; if (region_diff(16'h7FFF, 2) != 0) begin fails++; $display("FAIL wrap_data got %0d bad bytes want 0", region_diff(16'h7FFF, 2)); end
   endtask

   task automatic test_reset_mid();
      int cnt, d;
      for (int i = 0; i < 5; i++) begin
         mem[16'h0500 + 16'(i)] = 8'hEE;
         ref_mem[16'h0500 + 16'(i)] = 8'hEE;
      end
      start_ch(1'b0, 1'b0, 16'h0400, 16'h0500, 8'd5);
      cnt = 0;
      for (int n = 0; n < 50 && cnt < 5; n++) begin
         @(posedge clk); #1;
         if (busy === 1'b1) cnt++;
      end
      @(negedge clk); #2;
      nReset = 1'b0;
      #1;
      tests++; if (nDMA_REQ !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL rmid_ndma got %b busy %b want 1/0", nDMA_REQ, busy); end
      tests++; if (address_bus !== 16'hFFFF || data_bus !== 8'hFF || {nRAM_RD, nRAM_WR} !== 2'b11) begin
         fails++; $display("FAIL rmid_bus got %h %h %b want released", address_bus, data_bus, {nRAM_RD, nRAM_WR}); end
      ch0_req = 1'b0;
      d = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (ch0_done === 1'b1 || ch1_done === 1'b1) d++;
      end
      tests++; if (d != 0) begin fails++; $display("FAIL rmid_done got %0d pulses want 0", d); end
      model_xfer(1'b0, 16'h0400, 16'h0500, 2);
      tests++; if (region_diff(16'h0500, 4) != 0) begin fails++; $display("FAIL rmid_bytes got %0d bad bytes want 0", region_diff(16'h0500, 4)); end
      @(negedge clk);
      nReset = 1'b1;
      rr = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      tests++; if (pc != 4) begin fails++; $display("FAIL rmid_cpu_resume got pc %0d want 4", pc); end
   endtask

   task automatic test_random();
      int cyc, low, d0, d1; int unsigned pcr, pcl; logic act; bit to;
      bit ch, fill;
      logic [15:0] src, dst;
      logic [7:0] len;
      for (int k = 0; k < 10; k++) begin
         ch   = 1'($urandom_range(0, 1));
         fill = 1'($urandom_range(0, 1));
         src  = 16'($urandom);
         dst  = 16'($urandom);
         len  = 8'($urandom_range(0, 16));
         start_ch(ch, 1'b0, 16'($urandom), 16'($urandom), 8'($urandom));
         if (ch) ch0_req = 1'b0; else ch1_req = 1'b0;
         start_ch(~ch, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 8'($urandom));
         if (ch) ch0_req = 1'b0; else ch1_req = 1'b0;
         start_ch(ch, fill, src, dst, len);
         model_xfer(fill, src, dst, int'(len));
         rr = ch;
         watch(cyc, low, d0, d1, pcr, pcl, act, to);
         tests++; if (to || cyc != exp_cycles(fill, int'(len)) || low != exp_low(fill, int'(len))) begin
            fails++; $display("FAIL rand_timing #%0d got %0d/%0d want %0d/%0d", k, cyc, low, exp_cycles(fill, int'(len)), exp_low(fill, int'(len))); end
         tests++; if (act !== ch || (ch ? d1 : d0) != 1 || (ch ? d0 : d1) != 0) begin
            fails++; $display("FAIL rand_done #%0d got ch %b %0d/%0d want ch %b", k, act, d0, d1, ch); end
         tests++; if (region_diff(dst, int'(len)) != 0) begin
            fails++; $display("FAIL rand_data #%0d got %0d bad bytes want 0", k, region_diff(dst, int'(len))); end
      end
   endtask

   task automatic test_bus_hygiene();
      tests++; if (hyg_err != 0) begin fails++; $display("FAIL bus_hygiene got %0d violations want 0", hyg_err); end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i] = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      test_reset();
      test_copy();
      test_fill();
      test_arbitration();
      test_zero_len();
      test_wrap();
      test_reset_mid();
      test_random();
      test_bus_hygiene();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end

endmodule
